// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, canonical NOP and the fetch FSM states.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_REQ,
    IF_WAIT
  } if_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: one-word line buffer in front of a req/gnt/rvalid bus,
// with a sticky error tag so a failed word is not refetched while the PC stays on it.
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [rv32i_pkg::XLEN-1:0] PC,
  output logic [rv32i_pkg::XLEN-1:0] instruction_code,
  output logic                       instr_valid,
  output logic                       fetch_stall,
  output logic                       fetch_fault,
  output logic                       mem_req,
  output logic [rv32i_pkg::XLEN-1:0] mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [rv32i_pkg::XLEN-1:0] mem_rdata,
  input  logic                       mem_err
);
  import rv32i_pkg::*;

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  if_state_e state, state_next;

  logic [TW-1:0] timer;
  logic          buf_valid;
  logic [29:0]   buf_tag;
  logic [31:0]   buf_data;
  logic          err_valid;
  logic [29:0]   err_tag;

  logic hit, ehit, misal, wait_done;

  assign misal     = PC[1:0] != 2'b00;
  assign hit       = buf_valid && (buf_tag == PC[31:2]);
  assign ehit      = err_valid && (err_tag == PC[31:2]);
  assign wait_done = mem_rvalid || (timer == T_LAST);

  // mem_addr doubles as the captured tag of the outstanding fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IF_IDLE;
      mem_addr  <= '0;
      timer     <= '0;
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      err_valid <= 1'b0;
      err_tag   <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IF_IDLE: begin
          if (!misal && !ehit && !hit) mem_addr <= {PC[31:2], 2'b00};
        end
        IF_REQ: begin
          if (mem_gnt) timer <= '0;
        end
        IF_WAIT: begin
          timer <= timer + TW'(1);
          if (mem_rvalid && !mem_err) begin
            buf_valid <= 1'b1;
            buf_tag   <= mem_addr[31:2];
            buf_data  <= mem_rdata;
            if (err_valid && (err_tag == mem_addr[31:2])) err_valid <= 1'b0;
          end else if (wait_done) begin
            err_valid <= 1'b1;
            err_tag   <= mem_addr[31:2];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next       = state;
    instr_valid      = 1'b0;
    fetch_fault      = 1'b0;
    instruction_code = NOP_INSTR;
    mem_req          = 1'b0;
    unique case (state)
      IF_IDLE: begin
        if (misal || ehit) begin
          fetch_fault = 1'b1;
        end else if (hit) begin
          instr_valid      = 1'b1;
          instruction_code = buf_data;
        end else begin
          state_next = IF_REQ;
        end
      end
      IF_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_next = IF_WAIT;
      end
      IF_WAIT: begin
        if (wait_done) state_next = IF_IDLE;
      end
      default: state_next = IF_IDLE;
    endcase
  end

  assign fetch_stall = !instr_valid && !fetch_fault;

endmodule
